// File: rtl/dff_shift_unit_if.sv
// Bus bundle for dff_shift_unit: load/shift controls in, register state and handshake out.
// The chg port exists only when DSU_EDGE_DET_EN is defined.
interface dff_shift_unit_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
);
  logic [WIDTH-1:0] d;
  logic             load;
  logic             start;
  logic [1:0]       op;
  logic [AMT_W-1:0] amt;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic             sout;
  logic             busy;
  logic             done;
`ifdef DSU_EDGE_DET_EN
  logic [WIDTH-1:0] chg;

  modport master (output d, load, start, op, amt, sin,
                  input  q, q_bar, sout, busy, done, chg);
  modport slave  (input  d, load, start, op, amt, sin,
                  output q, q_bar, sout, busy, done, chg);
`else
  modport master (output d, load, start, op, amt, sin,
                  input  q, q_bar, sout, busy, done);
  modport slave  (input  d, load, start, op, amt, sin,
                  output q, q_bar, sout, busy, done);
`endif
endinterface

// File: rtl/dff_shift_unit.sv
// WIDTH-bit register bank with complementary outputs, parallel load and a one-bit-per-clock
// shift/rotate engine. Define DSU_EDGE_DET_EN to add the per-bit toggle detector output chg.
module dff_shift_unit #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  dff_shift_unit_if.slave   bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] qbar_q, qbar_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             zpend_q, zpend_d;
  logic [WIDTH:0]   step;

  // One single-bit step; result is {bit leaving the register, new register value}.
  function automatic logic [WIDTH:0] shift_step(input logic [WIDTH-1:0] v,
                                                input logic [1:0]       mode,
                                                input logic             s);
    case (mode)
      2'b00:   shift_step = {v[WIDTH-1], v[WIDTH-2:0], s};
      2'b01:   shift_step = {v[0], s, v[WIDTH-1:1]};
      2'b10:   shift_step = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      default: shift_step = {v[0], v[0], v[WIDTH-1:1]};
    endcase
  endfunction

  assign step = shift_step(shreg_q, op_q, bus.sin);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    shreg_d = shreg_q;
    sout_d  = sout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    zpend_d = 1'b0;
    case (state_q)
      IDLE: begin
        // A zero-length request spends one quiet cycle so done lands after edge N+1.
        if (zpend_q) begin
          done_d = 1'b1;
        end else if (bus.load) begin
          shreg_d = bus.d;
        end else if (bus.start) begin
          if (bus.amt == '0) begin
            zpend_d = 1'b1;
          end else begin
            op_d    = bus.op;
            cnt_d   = bus.amt;
            busy_d  = 1'b1;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        shreg_d = step[WIDTH-1:0];
        sout_d  = step[WIDTH];
        cnt_d   = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    qbar_d = ~shreg_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      shreg_q <= '0;
      qbar_q  <= '1;
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      shreg_q <= shreg_d;
      qbar_q  <= qbar_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      zpend_q <= zpend_d;
    end
  end

`ifdef DSU_EDGE_DET_EN
  logic [WIDTH-1:0] chg_q, chg_d;

  always_comb begin
    chg_d = shreg_d ^ shreg_q;
  end

  always_ff @(posedge clk) begin
    if (rst) chg_q <= '0;
    else     chg_q <= chg_d;
  end

  assign bus.chg = chg_q;
`endif

  assign bus.q     = shreg_q;
  assign bus.q_bar = qbar_q;
  assign bus.sout  = sout_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_dff_shift_unit.sv
// Randomised self-checking bench for dff_shift_unit against an arithmetic reference model.
module tb_dff_shift_unit;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  dff_shift_unit_if #(.WIDTH(8), .AMT_W(4)) bus();

  dff_shift_unit #(.WIDTH(8), .AMT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference step using plain arithmetic on the register value.
  function automatic int ref_step(input int v, input int op, input int s, output int so);
    case (op)
      0: begin so = v / 128; ref_step = (v * 2 + s) % 256; end
      1: begin so = v % 2;   ref_step = v / 2 + s * 128; end
      2: begin so = v / 128; ref_step = (v * 2) % 256 + v / 128; end
      default: begin so = v % 2; ref_step = v / 2 + (v % 2) * 128; end
    endcase
  endfunction

  // Closed-form rotate by n positions (left when left=1).
  function automatic int ref_rot(input int v, input int n, input int left);
    int r;
    r = n % 8;
    if (r == 0) return v;
    if (left != 0) return ((v << r) | (v >> (8 - r))) & 255;
    return ((v >> r) | (v << (8 - r))) & 255;
  endfunction

  task automatic load_val(input logic [7:0] v);
    bus.d = v; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.load = 1'b1; bus.start = 1'b1; bus.d = 8'hFF; bus.amt = 4'd3;
    tick(); tick();
    rst = 1'b0; bus.load = 1'b0; bus.start = 1'b0;
    total++; if (bus.q !== 8'h00) $display("FAIL reset_q: got %h want 00", bus.q); else passed++;
    total++; if (bus.q_bar !== 8'hFF) $display("FAIL reset_qbar: got %h want ff", bus.q_bar); else passed++;
    total++; if ({bus.busy, bus.done, bus.sout} !== 3'b000)
      $display("FAIL reset_ctl: got busy/done/sout %b want 000", {bus.busy, bus.done, bus.sout}); else passed++;
  endtask

  task automatic test_load;
    load_val(8'hA5);
    total++; if (bus.q !== 8'hA5) $display("FAIL load_q: got %h want a5", bus.q); else passed++;
    total++; if (bus.q_bar !== 8'h5A) $display("FAIL load_qbar: got %h want 5a", bus.q_bar); else passed++;
    bus.d = 8'h3C; bus.load = 1'b1; bus.start = 1'b1; bus.amt = 4'd2; bus.op = 2'b10;
    tick();
    bus.load = 1'b0; bus.start = 1'b0;
    total++; if (bus.q !== 8'h3C) $display("FAIL load_prio_q: got %h want 3c", bus.q); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL load_prio_busy: got %b want 0", bus.busy); else passed++;
    tick();
    total++; if ({bus.busy, bus.done} !== 2'b00)
      $display("FAIL load_prio_nodone: got busy/done %b want 00", {bus.busy, bus.done}); else passed++;
  endtask

  task automatic test_rotate;
    logic [7:0] exp_q [3];
    exp_q[0] = 8'h03; exp_q[1] = 8'h06; exp_q[2] = 8'h0C;
    load_val(8'h81);
    bus.op = 2'b10; bus.amt = 4'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    total++; if ({bus.busy, bus.done, bus.q} !== {2'b10, 8'h81})
      $display("FAIL rot_accept: got busy/done/q %b %b %h want 1 0 81", bus.busy, bus.done, bus.q); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.q !== exp_q[i]) $display("FAIL rot_step%0d: got %h want %h", i, bus.q, exp_q[i]); else passed++;
      total++; if ({bus.busy, bus.done} !== ((i < 2) ? 2'b10 : 2'b01))
        $display("FAIL rot_hs%0d: got busy/done %b", i, {bus.busy, bus.done}); else passed++;
    end
    total++; if (bus.sout !== 1'b0) $display("FAIL rot_sout: got %b want 0", bus.sout); else passed++;
    tick();
    total++; if (bus.done !== 1'b0) $display("FAIL rot_done_pulse: got %b want 0", bus.done); else passed++;
  endtask

  task automatic test_shift_sin;
    load_val(8'hF0);
    bus.op = 2'b00; bus.amt = 4'd2; bus.sin = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    total++; if ({bus.q, bus.sout} !== {8'hE1, 1'b1})
      $display("FAIL shl_step0: got %h/%b want e1/1", bus.q, bus.sout); else passed++;
    bus.start = 1'b1; bus.op = 2'b11; bus.amt = 4'd5;
    tick();
    bus.start = 1'b0;
    total++; if ({bus.q, bus.sout, bus.busy, bus.done} !== {8'hC3, 3'b101})
      $display("FAIL shl_step1: got %h sout %b busy %b done %b want c3 1 0 1", bus.q, bus.sout, bus.busy, bus.done); else passed++;
    tick();
    total++; if ({bus.q, bus.busy, bus.done} !== {8'hC3, 2'b00})
      $display("FAIL shl_midstart: got %h busy %b done %b want c3 0 0", bus.q, bus.busy, bus.done); else passed++;
  endtask

  task automatic test_zero_amt;
    load_val(8'h5B);
    bus.amt = 4'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    total++; if ({bus.busy, bus.done} !== 2'b00)
      $display("FAIL zero_n: got busy/done %b want 00", {bus.busy, bus.done}); else passed++;
    tick();
    total++; if ({bus.busy, bus.done, bus.q} !== {2'b01, 8'h5B})
      $display("FAIL zero_n1: got busy/done %b q %h want 01 5b", {bus.busy, bus.done}, bus.q); else passed++;
    tick();
    total++; if (bus.done !== 1'b0) $display("FAIL zero_pulse: got %b want 0", bus.done); else passed++;
  endtask

  task automatic test_abort;
    int seen_done;
    load_val(8'h5A);
    bus.op = 2'b00; bus.amt = 4'd5; bus.sin = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    total++; if (bus.q !== 8'h68) $display("FAIL abort_pre: got %h want 68", bus.q); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if ({bus.q, bus.q_bar, bus.busy, bus.done} !== {8'h00, 8'hFF, 2'b00})
      $display("FAIL abort_rst: got q %h qbar %h busy %b done %b", bus.q, bus.q_bar, bus.busy, bus.done); else passed++;
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen_done++;
    end
    total++; if (seen_done != 0) $display("FAIL abort_nodone: got %0d active cycles want 0", seen_done); else passed++;
  endtask

  task automatic test_back_to_back;
    load_val(8'h96);
    bus.op = 2'b11; bus.amt = 4'd2; bus.start = 1'b1;
    tick(); tick(); tick();
    total++; if ({bus.q, bus.busy, bus.done} !== {8'hA5, 2'b01})
      $display("FAIL b2b_first: got q %h busy %b done %b want a5 0 1", bus.q, bus.busy, bus.done); else passed++;
    tick();
    bus.start = 1'b0;
    total++; if ({bus.busy, bus.done} !== 2'b10)
      $display("FAIL b2b_retrig: got busy/done %b want 10", {bus.busy, bus.done}); else passed++;
    tick(); tick();
    total++; if ({bus.q, bus.done} !== {8'(ref_rot(32'h96, 4, 0)), 1'b1})
      $display("FAIL b2b_second: got q %h done %b want %h 1", bus.q, bus.done, ref_rot(32'h96, 4, 0)); else passed++;
    tick();
  endtask

  task automatic test_random;
    int v0, v, so, op, amt, s, bad_busy;
    for (int it = 0; it < 24; it++) begin
      v0 = int'($urandom_range(0, 255));
      load_val(8'(v0));
      total++; if (bus.q !== 8'(v0)) $display("FAIL rnd_load%0d: got %h want %h", it, bus.q, v0); else passed++;
      op  = int'($urandom_range(0, 3));
      amt = int'($urandom_range(0, 15));
      bus.op = 2'(op); bus.amt = 4'(amt); bus.sin = 1'($urandom_range(0, 1)); bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      v = v0; so = 0; bad_busy = 0;
      if (amt == 0) begin
        tick();
        total++; if ({bus.q, bus.busy, bus.done} !== {8'(v0), 2'b01})
          $display("FAIL rnd_zero%0d: got q %h busy %b done %b want %h 0 1", it, bus.q, bus.busy, bus.done, v0); else passed++;
      end else begin
        for (int k = 0; k < amt; k++) begin
          if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad_busy++;
          s = int'($urandom_range(0, 1));
          bus.sin = 1'(s);
          v = ref_step(v, op, s, so);
          tick();
          total++; if (bus.q !== 8'(v))
            $display("FAIL rnd_step%0d_%0d: op %0d got %h want %h", it, k, op, bus.q, v); else passed++;
        end
        total++; if (bad_busy != 0) $display("FAIL rnd_busy%0d: got %0d bad cycles want 0", it, bad_busy); else passed++;
        total++; if ({bus.busy, bus.done, bus.sout} !== {2'b01, 1'(so)})
          $display("FAIL rnd_end%0d: got busy/done/sout %b want 01%0d", it, {bus.busy, bus.done, bus.sout}, so); else passed++;
        if (op >= 2) begin
          total++; if (bus.q !== 8'(ref_rot(v0, amt, (op == 2) ? 1 : 0)))
            $display("FAIL rnd_rot%0d: got %h want %h", it, bus.q, ref_rot(v0, amt, (op == 2) ? 1 : 0)); else passed++;
        end
      end
      tick();
      total++; if (bus.done !== 1'b0) $display("FAIL rnd_pulse%0d: got %b want 0", it, bus.done); else passed++;
      total++; if (bus.q_bar !== ~bus.q) $display("FAIL rnd_qbar%0d: got %h want %h", it, bus.q_bar, ~bus.q); else passed++;
    end
  endtask

`ifdef DSU_EDGE_DET_EN
  task automatic test_chg;
    load_val(8'hFF);
    load_val(8'h0F);
    total++; if (bus.chg !== 8'hF0) $display("FAIL chg_load: got %h want f0", bus.chg); else passed++;
    tick();
    total++; if (bus.chg !== 8'h00) $display("FAIL chg_clear: got %h want 00", bus.chg); else passed++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clk = 1'b0; rst = 1'b0; passed = 0; total = 0;
    bus.d = '0; bus.load = 1'b0; bus.start = 1'b0; bus.op = '0; bus.amt = '0; bus.sin = 1'b0;
    test_reset();
    test_load();
    test_rotate();
    test_shift_sin();
    test_zero_amt();
    test_abort();
    test_back_to_back();
    test_random();
`ifdef DSU_EDGE_DET_EN
    test_chg();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
